// File: rtl/enc_event_pkg.sv
// Shared types for the encoder event queue.
// enc_event_t is the 8-bit event word handed to the CPU; the queue stores the
// same layout, and the valid/overflow fields are filled in when a word is popped.
package enc_event_pkg;

    typedef struct packed {
        logic [2:0] cnt;    // number of merged detent clicks
        logic       ovf;    // an event was dropped since the previous read
        logic       vld;    // word carries a queued event
        logic       sw;     // push-switch level
        logic       cw;     // rotation direction, 1 = clockwise
        logic       click;  // event is a detent click
    } enc_event_t;

    localparam int BIT_CLICK  = 0;
    localparam int BIT_CW     = 1;
    localparam int BIT_SW     = 2;
    localparam int BIT_VLD    = 3;
    localparam int BIT_OVF    = 4;
    localparam int BIT_CNT_LO = 5;

    localparam logic [2:0] CNT_MAX = 3'd7;

    // Build a fresh queue entry from the decode-stage inputs.
    function automatic enc_event_t make_entry(input logic click, input logic cw, input logic sw);
        enc_event_t e;
        e       = 8'h00;
        e.click = click;
        e.cw    = cw;
        e.sw    = sw;
        e.cnt   = click ? 3'd1 : 3'd0;
        return e;
    endfunction

endpackage

// File: rtl/enc_event_fifo.sv
// Circular event store for the encoder queue.
// Ports: clk/reset (sync, active-high); push writes wr_data at the tail;
// pop advances the head; rewrite replaces the most recently written entry
// with rewrite_data (used when clicks are merged). head_data/tail_data are
// combinational views of the oldest and newest entries. level is the
// registered entry count (0..DEPTH); nonempty_next is what level != 0 will
// be after the coming edge.
module enc_event_fifo
    import enc_event_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             rewrite,
    input  enc_event_t       wr_data,
    input  enc_event_t       rewrite_data,
    output enc_event_t       head_data,
    output enc_event_t       tail_data,
    output logic [LVL_W-1:0] level,
    output logic             nonempty_next
);

    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [LVL_W-1:0] LVL_ONE = {{(LVL_W-1){1'b0}}, 1'b1};

    enc_event_t       mem_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [PTR_W-1:0] tail_last_s;
    logic [LVL_W-1:0] level_r;
    logic [LVL_W-1:0] level_next_s;

    // Newest entry sits one slot behind the write pointer (wraps naturally).
    assign tail_last_s = tail_r - PTR_ONE;
    assign head_data   = mem_r[head_r];
    assign tail_data   = mem_r[tail_last_s];
    assign level       = level_r;

    // Next entry count from this cycle's push/pop pair.
    always_comb begin
        level_next_s = level_r;
        case ({push, pop})
            2'b10:   level_next_s = level_r + LVL_ONE;
            2'b01:   level_next_s = level_r - LVL_ONE;
            default: level_next_s = level_r;
        endcase
        nonempty_next = (level_next_s != {LVL_W{1'b0}});
    end

    // Entry storage; contents are don't-care until covered by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[tail_r] <= wr_data;
        end else if (rewrite) begin
            mem_r[tail_last_s] <= rewrite_data;
        end
    end

    // Pointers and entry counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            level_r <= {LVL_W{1'b0}};
        end else begin
            if (push) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (pop) begin
                head_r <= head_r + PTR_ONE;
            end
            level_r <= level_next_s;
        end
    end

endmodule

// File: rtl/encoder_event_queue.sv
// Encoder event queue: buffers encoder state changes for CPU polling.
// Optional feature macro: ENC_EVENT_COALESCE_EN merges repeated identical
// clicks into the newest entry (count up to 7) instead of consuming slots.
// Ports: clk, reset (sync, active-high); event_stb with click/clockwise/switch
// qualifiers; rd_stb pops the oldest entry into event_reg. Outputs: event_reg
// (registered event word), level (entries queued), irq (level != 0),
// overflow (sticky drop flag, cleared by any read).
module encoder_event_queue
    import enc_event_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             event_stb,
    input  logic             click,
    input  logic             clockwise,
    input  logic             switch,
    input  logic             rd_stb,
    output logic [7:0]       event_reg,
    output logic [LVL_W-1:0] level,
    output logic             irq,
    output logic             overflow
);

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [LVL_W-1:0] level_s;
    logic             nonempty_next_s;
    logic             empty_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic             merge_s;
    logic             drop_s;
    enc_event_t       in_entry_s;
    enc_event_t       head_s;
    enc_event_t       merged_s;
    logic [7:0]       pop_word_s;
    logic [7:0]       empty_word_s;
    logic [7:0]       event_r;
    logic             overflow_r;
    logic             irq_r;

    assign empty_s    = (level_s == {LVL_W{1'b0}});
    assign full_s     = (level_s == FULL_LVL);
    assign pop_s      = rd_stb && !empty_s;
    assign in_entry_s = make_entry(click, clockwise, switch);

`ifdef ENC_EVENT_COALESCE_EN
    localparam logic [LVL_W-1:0] LVL_ONE = {{(LVL_W-1){1'b0}}, 1'b1};
    enc_event_t tail_s;

    // Merge a click into an identical newest entry unless that entry is leaving now.
    always_comb begin
        merged_s     = tail_s;
        merged_s.cnt = tail_s.cnt + 3'd1;
        if (event_stb && click && !empty_s && tail_s.click &&
            (tail_s.cw == clockwise) && (tail_s.sw == switch) &&
            (tail_s.cnt < CNT_MAX) && !(rd_stb && (level_s == LVL_ONE))) begin
            merge_s = 1'b1;
        end else begin
            merge_s = 1'b0;
        end
    end
`else
    assign merge_s  = 1'b0;
    assign merged_s = 8'h00;
`endif

    // A full queue still accepts an event when a pop frees a slot in the same cycle.
    assign push_s = event_stb && !merge_s && (!full_s || pop_s);
    assign drop_s = event_stb && !merge_s && full_s && !pop_s;

    enc_event_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (push_s),
        .pop          (pop_s),
        .rewrite      (merge_s),
        .wr_data      (in_entry_s),
        .rewrite_data (merged_s),
        .head_data    (head_s),
`ifdef ENC_EVENT_COALESCE_EN
        .tail_data    (tail_s),
`else
        .tail_data    (),
`endif
        .level        (level_s),
        .nonempty_next(nonempty_next_s)
    );

    // Words presented to the CPU for a successful and an empty read.
    always_comb begin
        pop_word_s            = head_s;
        pop_word_s[BIT_VLD]   = 1'b1;
        pop_word_s[BIT_OVF]   = overflow_r;
        empty_word_s          = 8'h00;
        empty_word_s[BIT_OVF] = overflow_r;
    end

    // Event word, sticky overflow and interrupt registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            event_r    <= 8'h00;
            overflow_r <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            irq_r <= nonempty_next_s;
            // A drop in the same cycle as a read keeps the flag for the next read.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (rd_stb) begin
                overflow_r <= 1'b0;
            end
            if (rd_stb) begin
                event_r <= pop_s ? pop_word_s : empty_word_s;
            end
        end
    end

    assign event_reg = event_r;
    assign level     = level_s;
    assign irq       = irq_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_encoder_event_queue.sv
module tb_encoder_event_queue;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       event_stb = 1'b0;
    logic       click = 1'b0;
    logic       clockwise = 1'b0;
    logic       switch = 1'b0;
    logic       rd_stb = 1'b0;
    logic [7:0] event_reg;
    logic [3:0] level;
    logic       irq;
    logic       overflow;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       e;
        logic       c;
        logic       w;
        logic       s;
        logic       r;
        logic [7:0] ev;
        int         lvl;
        logic       irq;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];

    encoder_event_queue #(.DEPTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .event_stb(event_stb),
        .click    (click),
        .clockwise(clockwise),
        .switch   (switch),
        .rd_stb   (rd_stb),
        .event_reg(event_reg),
        .level    (level),
        .irq      (irq),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_all(input string nm, input logic [7:0] ev, input int lvl,
                              input logic ir, input logic ov);
        chk({nm, ".event_reg"}, int'(event_reg), int'(ev));
        chk({nm, ".level"}, int'(level), lvl);
        chk({nm, ".irq"}, int'(irq), int'(ir));
        chk({nm, ".overflow"}, int'(overflow), int'(ov));
    endtask

    // One clock with the given strobes; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic e, input logic c, input logic w, input logic s, input logic r);
        event_stb = e; click = c; clockwise = w; switch = s; rd_stb = r;
        @(posedge clk);
        #1;
        event_stb = 1'b0; click = 1'b0; clockwise = 1'b0; switch = 1'b0; rd_stb = 1'b0;
    endtask

    task automatic add(input logic e, input logic c, input logic w, input logic s, input logic r,
                       input logic [7:0] ev, input int lvl, input logic ir, input logic ov);
        vec_t v;
        v.e = e; v.c = c; v.w = w; v.s = s; v.r = r;
        v.ev = ev; v.lvl = lvl; v.irq = ir; v.ovf = ov;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_all("reset", 8'h00, 0, 1'b0, 1'b0);

`ifndef ENC_EVENT_COALESCE_EN
        // Basic push/pop, empty reads, empty read with simultaneous push.
        add(0,0,0,0,1, 8'h00, 0, 0, 0);
        add(1,1,1,0,0, 8'h00, 1, 1, 0);
        add(1,1,1,0,0, 8'h00, 2, 1, 0);
        add(1,1,1,0,0, 8'h00, 3, 1, 0);
        add(0,0,0,0,1, 8'h2B, 2, 1, 0);
        add(0,0,0,0,1, 8'h2B, 1, 1, 0);
        add(0,0,0,0,1, 8'h2B, 0, 0, 0);
        add(0,0,0,0,1, 8'h00, 0, 0, 0);
        add(1,0,0,1,1, 8'h00, 1, 1, 0);
        add(0,0,0,0,1, 8'h0C, 0, 0, 0);
        add(0,0,0,0,0, 8'h0C, 0, 0, 0);
        // DEPTH+2 events with no reads: two drops.
        for (int i = 0; i < 10; i++) begin
            add(1,1,1,0,0, 8'h0C, (i < 8) ? i + 1 : 8, 1, (i >= 8));
        end
        add(0,0,0,0,1, 8'h3B, 7, 1, 0);
        for (int k = 6; k >= 0; k--) begin
            add(0,0,0,0,1, 8'h2B, k, (k != 0), 0);
        end
        add(0,0,0,0,1, 8'h00, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].e, tbl[i].c, tbl[i].w, tbl[i].s, tbl[i].r);
            expect_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].lvl, tbl[i].irq, tbl[i].ovf);
        end

        // Full queue with simultaneous push and pop: no drop, newest entry read last.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        chk("fill8.level", int'(level), 8);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_all("full_pushpop", 8'h2B, 8, 1'b1, 1'b0);
        for (int k = 7; k >= 1; k--) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            expect_all($sformatf("drain%0d", k), 8'h2B, k, 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_all("newest_last", 8'h0C, 0, 1'b0, 1'b0);

        // Drop, then a read coinciding with a push at full: flag reported and cleared.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        expect_all("drop", 8'h0C, 8, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_all("ovf_read_full", 8'h39, 8, 1'b1, 1'b0);

        // Reset wins over same-cycle strobes.
        do_reset();
        expect_all("reset_override", 8'h00, 0, 1'b0, 1'b0);
`else
        // Nine ccw clicks coalesce into counts 7 and 2.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            chk($sformatf("ccw%0d.level", i), int'(level), (i < 7) ? 1 : 2);
        end
        chk("ccw.overflow", int'(overflow), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_all("coal_rd0", 8'hE9, 1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_all("coal_rd1", 8'h49, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_all("coal_rd2", 8'h00, 0, 1'b0, 1'b0);

        // A switch event breaks the merge chain.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("sw_chain.level", int'(level), 3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_all("sw_rd0", 8'h2B, 2, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_all("sw_rd1", 8'h0C, 1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_all("sw_rd2", 8'h2B, 0, 1'b0, 1'b0);

        // No merge into the sole entry while it is being popped.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_all("pop_tail", 8'h2B, 1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_all("pop_tail_rd", 8'h2B, 0, 1'b0, 1'b0);

        do_reset();
        expect_all("reset_override", 8'h00, 0, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
